// File: rtl/i2c_slave_regfile_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile_if
//
// Pin-level bundle for the I2C target. The pins are open-drain on the board:
// the target only ever pulls SDA low through sda_oe and never drives SCL.
//
//   scl_in  raw SCL pin level as seen by the target
//   sda_in  raw SDA pin level as seen by the target (wired-AND of all drivers)
//   sda_oe  1 = target pulls SDA low, 0 = target releases SDA
//
// Modports:
//   master  bus side (board model / testbench): drives the pin levels
//   slave   target side: samples the pins, drives sda_oe
// ---------------------------------------------------------------------------
interface i2c_slave_regfile_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe
    );

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe
    );
endinterface

// File: rtl/i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// i2c_slave_regfile
//
// Generic I2C target holding NUM_REGS 8-bit registers. A write transaction
// sends a register pointer followed by any number of data bytes, written at
// an auto-incrementing pointer. A read transaction (usually after a repeated
// START) streams registers out from the current pointer. A commit strobe at
// STOP tells downstream logic that the register image changed.
//
// Ports:
//   clock      system clock, at least 20x the SCL rate
//   reset      synchronous, active-high; aborts any transaction
//   bus        i2c_slave_regfile_if.slave (scl_in, sda_in, sda_oe)
//   reg_flat   register file image, register i at bits [8i+7:8i]
//   wr_strobe  one-clock pulse per data byte written
//   wr_index   register index written, valid with wr_strobe
//   commit     one-clock pulse at STOP if the transaction wrote any byte
//   busy       high from an address-matched START until the following STOP
// ---------------------------------------------------------------------------
module i2c_slave_regfile #(
    parameter logic [6:0]            I2C_ADDR    = 7'h69,
    parameter int                    NUM_REGS    = 16,
    parameter int                    PTR_W       = 7,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [NUM_REGS*8-1:0] RESET_VAL   = {NUM_REGS{8'h00}}
) (
    input  logic                  clock,
    input  logic                  reset,
    i2c_slave_regfile_if.slave    bus,
    output logic [NUM_REGS*8-1:0] reg_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  commit,
    output logic                  busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_NACK_WAIT
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REGS - 1);

    // Pin synchronisers and edge/condition detection
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    // Protocol state
    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   rw_bit;
    logic [PTR_W-1:0]       ptr;
    logic                   wr_flag;

    // Register file and helpers
    logic [7:0]             regs [NUM_REGS];
    logic [7:0]             rd_byte;
    logic [PTR_W-1:0]       ptr_inc;
    logic                   ptr_ok;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    // SDA may only move while SCL is high to signal START or STOP.
    assign start_det =  scl_s &  scl_prev &  sda_prev & ~sda_s;
    assign stop_det  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

    // Pins reset to the idle bus level so leaving reset never looks like a
    // START or STOP.
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev <= scl_s;
            sda_prev <= sda_s;
        end
    end

    // Register addressed by the pointer; a compare per register keeps the
    // pointer width independent of the register count.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr == PTR_W'(i)) begin
                rd_byte = regs[i];
            end
        end
    end

    assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    assign ptr_ok  = (32'(shreg) < NUM_REGS);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = regs[g];
    end

    // Protocol engine. STOP beats START beats the per-state work, so a STOP
    // landing on a byte boundary discards the byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            rw_bit     <= 1'b0;
            ptr        <= '0;
            wr_flag    <= 1'b0;
            bus.sda_oe <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_index   <= '0;
            commit     <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL[8*i +: 8];
            end
        end else begin
            wr_strobe <= 1'b0;
            commit    <= 1'b0;

            if (stop_det) begin
                state      <= S_IDLE;
                bit_cnt    <= '0;
                bus.sda_oe <= 1'b0;
                busy       <= 1'b0;
                commit     <= wr_flag;
                wr_flag    <= 1'b0;
            end else if (start_det) begin
                state      <= S_ADDR;
                bit_cnt    <= '0;
                bus.sda_oe <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        // The byte is judged one clock after its 8th SCL rise.
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (shreg[7:1] == I2C_ADDR) begin
                                rw_bit <= shreg[0];
                                busy   <= 1'b1;
                                state  <= S_ADDR_ACK;
                            end else begin
                                state  <= S_IDLE;
                            end
                        end else if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    S_PTR: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            if (ptr_ok) begin
                                ptr   <= PTR_W'(shreg);
                                state <= S_PTR_ACK;
                            end else begin
                                state <= S_NACK_WAIT;
                            end
                        end else if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    S_WDATA: begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt   <= '0;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (ptr == PTR_W'(i)) begin
                                    regs[i] <= shreg;
                                end
                            end
                            wr_strobe <= 1'b1;
                            wr_index  <= ptr;
                            wr_flag   <= 1'b1;
                            ptr       <= ptr_inc;
                            state     <= S_WDATA_ACK;
                        end else if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end

                    // bit_cnt 0: waiting for the 8th SCL fall to start the
                    // ACK; bit_cnt 1: holding ACK until the 9th SCL fall.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                bus.sda_oe <= 1'b1;
                                bit_cnt    <= 4'd1;
                            end else begin
                                bit_cnt <= '0;
                                if (state == S_ADDR_ACK && rw_bit) begin
                                    shreg      <= rd_byte;
                                    bus.sda_oe <= ~rd_byte[7];
                                    state      <= S_RDATA;
                                end else begin
                                    bus.sda_oe <= 1'b0;
                                    state      <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                                end
                            end
                        end
                    end

                    // The MSB is already on the bus on entry; bit_cnt counts
                    // the further bits shifted out.
                    S_RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd7) begin
                                bus.sda_oe <= 1'b0;
                                bit_cnt    <= '0;
                                state      <= S_RACK;
                            end else begin
                                shreg      <= {shreg[6:0], 1'b0};
                                bus.sda_oe <= ~shreg[6];
                                bit_cnt    <= bit_cnt + 4'd1;
                            end
                        end
                    end

                    // The pointer advances on the master's ACK/NACK sample;
                    // the next byte is fetched at the 9th fall so it reflects
                    // the register contents at that moment.
                    S_RACK: begin
                        if (bit_cnt == 4'd0) begin
                            if (scl_rise) begin
                                ptr <= ptr_inc;
                                if (sda_s) begin
                                    state <= S_NACK_WAIT;
                                end else begin
                                    bit_cnt <= 4'd1;
                                end
                            end
                        end else if (scl_fall) begin
                            shreg      <= rd_byte;
                            bus.sda_oe <= ~rd_byte[7];
                            bit_cnt    <= '0;
                            state      <= S_RDATA;
                        end
                    end

                    S_IDLE, S_NACK_WAIT: begin
                        bit_cnt <= '0;
                    end

                    default: begin
                        state      <= S_IDLE;
                        bus.sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regfile
//
// Bit-banged I2C master driving i2c_slave_regfile, with a transaction-level
// model of the register file (array + pointer) providing expected values.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regfile;

    localparam int NUM_REGS = 16;
    localparam int PTR_W    = 7;
    localparam int Q        = 6;   // quarter SCL period in clocks

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  scl_m;
    logic                  sda_m;
    logic [NUM_REGS*8-1:0] reg_flat;
    logic                  wr_strobe;
    logic [PTR_W-1:0]      wr_index;
    logic                  commit;
    logic                  busy;

    always #5 clock = ~clock;

    i2c_slave_regfile_if bus();

    // Open-drain wired-AND of master and target on SDA
    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_slave_regfile #(
        .I2C_ADDR    (7'h69),
        .NUM_REGS    (NUM_REGS),
        .PTR_W       (PTR_W),
        .SYNC_STAGES (2),
        .RESET_VAL   ({NUM_REGS{8'h00}})
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .reg_flat  (reg_flat),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .commit    (commit),
        .busy      (busy)
    );

    // Running event totals, sampled on the falling clock edge
    int               strobe_total = 0;
    int               commit_total = 0;
    int               busy_cycles  = 0;
    int               oe_cycles    = 0;
    logic [PTR_W-1:0] idx_log[$];

    always @(negedge clock) begin
        if (wr_strobe) begin
            strobe_total++;
            idx_log.push_back(wr_index);
        end
        if (commit)     commit_total++;
        if (busy)       busy_cycles++;
        if (bus.sda_oe) oe_cycles++;
    end

    // Behavioural model: the register array and pointer, updated per transaction
    logic [7:0] m_regs [NUM_REGS];
    int         m_ptr;
    int         exp_idx[$];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]      addr;
        logic [7:0]      ptr;
        int              n;
        logic [3:0][7:0] d;
        logic [5:0]      exp_acks;
        int              exp_strobes;
        int              exp_commits;
        bit              silent;
    } vec_t;

    vec_t vecs [4];

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [NUM_REGS*8-1:0] model_flat();
        logic [NUM_REGS*8-1:0] f;
        for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endfunction

    // Expected ACK pattern of a write transaction (bit 0 address, bit 1
    // pointer, bits 2.. data) and its effect on the model.
    function automatic logic [5:0] model_write(input logic [7:0] a, input logic [7:0] p,
                                               input int n, input logic [3:0][7:0] d);
        logic [5:0] m;
        m = '0;
        exp_idx.delete();
        if (a != 8'hD2) return m;
        m[0] = 1'b1;
        if (int'(p) >= NUM_REGS) return m;
        m[1] = 1'b1;
        m_ptr = int'(p);
        for (int k = 0; k < n; k++) begin
            m_regs[m_ptr] = d[k];
            exp_idx.push_back(m_ptr);
            m_ptr = (m_ptr + 1) % NUM_REGS;
            m[2+k] = 1'b1;
        end
        return m;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(2*Q);
    endtask

    task automatic bus_write_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2*Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_read_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = bus.sda_in; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_write_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bus_write_bit(v[i]);
        bus_read_bit(b);
        ack = ~b;
    endtask

    task automatic bus_read_byte(input logic send_ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bus_read_bit(b);
            v[i] = b;
        end
        bus_write_bit(~send_ack);
    endtask

    // Full write transaction: START, address, pointer, n data bytes, STOP
    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] p, input int n,
                                  input logic [3:0][7:0] d, output logic [5:0] acks);
        logic ack;
        acks = '0;
        bus_start();
        bus_write_byte(a, ack); acks[0] = ack;
        bus_write_byte(p, ack); acks[1] = ack;
        for (int k = 0; k < n; k++) begin
            bus_write_byte(d[k], ack);
            acks[2+k] = ack;
        end
        bus_stop();
    endtask

    // Read transaction, optionally setting the pointer first and using a
    // repeated START; the master ACKs every byte but the last.
    task automatic run_read(input bit set_ptr, input logic [7:0] p, input int n,
                            output logic [3:0][7:0] rd, output logic [2:0] acks,
                            output logic busy_mid);
        logic ack;
        logic [7:0] v;
        acks = '0;
        rd   = '0;
        bus_start();
        if (set_ptr) begin
            bus_write_byte(8'hD2, ack); acks[0] = ack;
            bus_write_byte(p, ack);     acks[1] = ack;
            bus_start();
        end
        bus_write_byte(8'hD3, ack); acks[2] = ack;
        busy_mid = busy;
        for (int k = 0; k < n; k++) begin
            bus_read_byte(k < n - 1, v);
            rd[k] = v;
        end
        bus_stop();
    endtask

    // Compare one write transaction against expectations
    task automatic run_write_checked(input string tag, input logic [7:0] a, input logic [7:0] p,
                                     input int n, input logic [3:0][7:0] d,
                                     input logic [5:0] exp_acks, input int exp_strobes,
                                     input int exp_commits, input bit silent);
        int s0, c0, b0, o0, i0;
        logic [5:0] acks;
        s0 = strobe_total; c0 = commit_total; b0 = busy_cycles; o0 = oe_cycles;
        i0 = idx_log.size();
        void'(model_write(a, p, n, d));
        apply_stimulus(a, p, n, d, acks);
        check_output({tag, "_acks"}, acks, exp_acks);
        check_output({tag, "_strobes"}, strobe_total - s0, exp_strobes);
        check_output({tag, "_commits"}, commit_total - c0, exp_commits);
        check_output({tag, "_regs"}, reg_flat, model_flat());
        check_output({tag, "_busy_after"}, busy, 1'b0);
        for (int k = 0; k < exp_idx.size(); k++) begin
            if (i0 + k < idx_log.size())
                check_output($sformatf("%s_idx%0d", tag, k), idx_log[i0+k], exp_idx[k]);
        end
        if (silent) begin
            check_output({tag, "_oe_quiet"}, oe_cycles - o0, 0);
            check_output({tag, "_busy_quiet"}, busy_cycles - b0, 0);
        end
    endtask

    initial begin
        logic [3:0][7:0] rd;
        logic [2:0]      racks;
        logic            bmid;
        logic [5:0]      exp_m;
        logic [3:0][7:0] d;
        logic [7:0]      p;
        int              n, c0, s0;

        vecs[0] = '{8'hD2, 8'h00, 4, {8'hC0, 8'hCF, 8'h6A, 8'h00}, 6'b111111, 4, 1, 1'b0};
        vecs[1] = '{8'hD2, 8'h0F, 2, {8'h00, 8'h00, 8'h55, 8'hAA}, 6'b001111, 2, 1, 1'b0};
        vecs[2] = '{8'hA0, 8'h12, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 6'b000000, 0, 0, 1'b1};
        vecs[3] = '{8'hD2, 8'h20, 2, {8'h00, 8'h00, 8'h22, 8'h11}, 6'b000001, 0, 0, 1'b0};

        reset = 1'b1;
        scl_m = 1'b1;
        sda_m = 1'b1;
        model_reset();
        tick(5);
        check_output("reset_sda_oe", bus.sda_oe, 1'b0);
        check_output("reset_regs", reg_flat, '0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_strobe", wr_strobe, 1'b0);
        check_output("reset_commit", commit, 1'b0);
        reset = 1'b0;
        tick(5);

        for (int v = 0; v < 4; v++) begin
            run_write_checked($sformatf("vec%0d", v), vecs[v].addr, vecs[v].ptr, vecs[v].n,
                              vecs[v].d, vecs[v].exp_acks, vecs[v].exp_strobes,
                              vecs[v].exp_commits, vecs[v].silent);
        end
        check_output("wrap_reg15", reg_flat[15*8 +: 8], 8'hAA);
        check_output("wrap_reg0", reg_flat[7:0], 8'h55);

        // Current-address read: the pointer was left at 1 by the wrap write
        run_read(1'b0, 8'h00, 1, rd, racks, bmid);
        check_output("curaddr_ack", racks[2], 1'b1);
        check_output("curaddr_data", rd[0], 8'h6A);
        m_ptr = (m_ptr + 1) % NUM_REGS;

        // Pointer write, repeated START, three reads
        c0 = commit_total;
        run_read(1'b1, 8'h02, 3, rd, racks, bmid);
        check_output("sr_acks", racks, 3'b111);
        check_output("sr_busy_mid", bmid, 1'b1);
        check_output("sr_data0", rd[0], 8'hCF);
        check_output("sr_data1", rd[1], 8'hC0);
        check_output("sr_data2", rd[2], 8'h00);
        check_output("sr_no_commit", commit_total - c0, 0);
        m_ptr = 5;

        // Randomized transactions against the model
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                p = 8'($urandom_range(0, 19));
                n = $urandom_range(1, 4);
                d = $urandom;
                exp_m = 6'b000001;
                if (int'(p) < NUM_REGS) begin
                    exp_m[1] = 1'b1;
                    for (int k = 0; k < n; k++) exp_m[2+k] = 1'b1;
                end
                run_write_checked($sformatf("rnd%0d_w", it), 8'hD2, p, n, d, exp_m,
                                  (int'(p) < NUM_REGS) ? n : 0,
                                  (int'(p) < NUM_REGS) ? 1 : 0, 1'b0);
            end else begin
                bit setp;
                setp = ($urandom_range(0, 1) == 1);
                p = 8'($urandom_range(0, NUM_REGS - 1));
                n = $urandom_range(1, 4);
                if (setp) m_ptr = int'(p);
                s0 = strobe_total;
                run_read(setp, p, n, rd, racks, bmid);
                check_output($sformatf("rnd%0d_r_ack", it), racks[2], 1'b1);
                for (int k = 0; k < n; k++)
                    check_output($sformatf("rnd%0d_r_data%0d", it, k), rd[k],
                                 m_regs[(m_ptr + k) % NUM_REGS]);
                check_output($sformatf("rnd%0d_r_nowrite", it), strobe_total - s0, 0);
                m_ptr = (m_ptr + n) % NUM_REGS;
            end
        end

        // Abort: reset while the target pulls SDA low during a read bit
        run_write_checked("abort_prep", 8'hD2, 8'h05, 1, 32'h0, 6'b000111, 1, 1, 1'b0);
        begin
            logic ack, b;
            bus_start();
            bus_write_byte(8'hD2, ack);
            bus_write_byte(8'h05, ack);
            bus_start();
            bus_write_byte(8'hD3, ack);
            for (int k = 0; k < 3; k++) bus_read_bit(b);
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            check_output("abort_driving", bus.sda_oe, 1'b1);
            reset = 1'b1;
            tick(1);
            check_output("abort_released", bus.sda_oe, 1'b0);
            reset = 1'b0;
            tick(2);
            model_reset();
            check_output("abort_regs", reg_flat, model_flat());
            check_output("abort_busy", busy, 1'b0);
            scl_m = 1'b0; tick(Q);
            bus_stop();
        end
        run_write_checked("post_abort", 8'hD2, 8'h03, 2, {8'h00, 8'h00, 8'h3C, 8'h9E},
                          6'b001111, 2, 1, 1'b0);
        run_read(1'b1, 8'h03, 2, rd, racks, bmid);
        check_output("post_abort_rd0", rd[0], 8'h9E);
        check_output("post_abort_rd1", rd[1], 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_slave_regfile.md
Name: i2c_slave_regfile

Overview:
- Parametrised successor to the fixed-format I2C control slave.
- Generic I2C target with a NUM_REGS x 8-bit register file, a register pointer with auto-increment, read-back, repeated-START support and a commit strobe.
- Sits between the MCU I2C bus and the DDC/DUC datapath. Downstream logic unpacks frequency, rate and level fields from reg_flat.

Parameters:
- I2C_ADDR, 7'h69, 7-bit target address; the R/W bit is excluded.
- NUM_REGS, 16, number of 8-bit registers; range 2..128.
- PTR_W, 7, pointer width; must satisfy 2**PTR_W >= NUM_REGS.
- SYNC_STAGES, 2, synchroniser flops on scl_in and sda_in; minimum 2.
- RESET_VAL, {NUM_REGS{8'h00}}, flat reset image of the register file; register i is bits [8i+7:8i].

Ports:
- clock  in  1  system clock; must be at least 20x the SCL rate.
- reset  in  1  synchronous, active-high.
- scl_in  in  1  raw SCL pin.
- sda_in  in  1  raw SDA pin.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- reg_flat  out  NUM_REGS*8  register file contents.
- wr_strobe  out  1  one-clock pulse per data byte written.
- wr_index  out  PTR_W  register index written; valid when wr_strobe = 1.
- commit  out  1  one-clock pulse at STOP when the transaction wrote at least one byte.
- busy  out  1  high between an address-matched START and the following STOP.

Behaviour:
- Bus conditioning: scl_in and sda_in pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
  - START / repeated START: SDA falls while SCL = 1.
  - STOP: SDA rises while SCL = 1.
  - Bits are sampled on the SCL rising edge, MSB first.
- Reset:
  - sda_oe = 0, reg_flat = RESET_VAL, pointer = 0.
  - wr_strobe = 0, commit = 0, busy = 0, state = IDLE.
  - Reset mid-transaction aborts the transaction; SDA is released in the same cycle.
- SDA timing: sda_oe changes only in the cycle after a detected SCL falling edge. Exceptions: reset, and STOP/START detection, which release SDA immediately.
- STOP in any state:
  - State -> IDLE, sda_oe = 0, busy = 0.
  - commit pulses 1 cycle if the write-flag was set; the write-flag then clears.
  - The pointer is retained.
- START in any state (including mid-byte): bit counter clears, state -> ADDR. The pointer and write-flag are retained.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Match on [7:1] == I2C_ADDR -> ADDR_ACK, busy = 1.
    - Mismatch -> IDLE; no ACK, bus untouched.
  - ADDR_ACK: drive ACK for the 9th clock.
    - R/W = 0 -> PTR.
    - R/W = 1 -> RDATA; load the shift register with reg[pointer].
  - PTR: shift 8 bits.
    - Value < NUM_REGS: pointer = value -> PTR_ACK.
    - Otherwise -> NACK_WAIT; SDA released on the 9th clock, pointer unchanged.
  - PTR_ACK: ACK -> WDATA.
  - WDATA: shift 8 bits. One clock after the 8th rising edge:
    - reg[pointer] = byte, wr_strobe = 1, wr_index = pointer.
    - Write-flag set; pointer increments, wrapping NUM_REGS-1 -> 0.
    - Next state WDATA_ACK.
  - WDATA_ACK: ACK -> WDATA.
  - RDATA: drive the shift register MSB first; the bit is set after each SCL falling edge, and sda_oe = ~bit. After 8 bits, release SDA -> RACK.
  - RACK: sample master ACK on the 9th rising edge.
    - ACK (SDA = 0): pointer increments with wrap, load reg[pointer] -> RDATA.
    - NACK: -> NACK_WAIT; the pointer still increments.
  - NACK_WAIT: hold SDA released until STOP or START.
- Simultaneous events:
  - A register write in the same cycle as reset is dropped.
  - STOP in the same cycle as the 8th-bit sample: the byte is discarded and no wr_strobe is issued.
- Read data reflects reg_flat at load time. Bytes written earlier in the same transaction are visible on reads after a repeated START.

Test Plan:
- Write burst: START, 0xD2, ptr 0x00, bytes 0x00 0x6A 0xCF 0xC0, STOP → ACK on all 6 bytes; reg0..3 = 00 6A CF C0; 4 wr_strobe pulses with wr_index 0..3; 1 commit at STOP; busy low after STOP.
- Wrap: NUM_REGS = 16, ptr 0x0F, bytes 0xAA 0x55 → reg15 = AA, reg0 = 55; pointer ends at 1.
- Read with repeated START: write ptr 0x02, Sr, 0xD3, master ACK, ACK, NACK → SDA carries reg2, reg3, reg4; no commit at STOP, since no data bytes were written.
- Address mismatch: START, 0xA0, 0x12, STOP → sda_oe stays 0 throughout; reg_flat unchanged; busy never rises.
- Bad pointer: ptr 0x20 with NUM_REGS = 16 → NACK on the pointer byte; following bytes ignored and NACKed; no wr_strobe.
- Abort: assert reset during bit 4 of a data byte while a read is driving SDA low → sda_oe = 0 the next cycle; reg_flat = RESET_VAL; next valid transaction succeeds.
